// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter between ALU and LSB result producers
//
// Two producers (ALU, LSB) compete for one broadcast slot per cycle. Each has a
// small FIFO that holds results that lost arbitration; per-source order is kept.
// The winner is broadcast from registered outputs.
//
// Build option: define CDB_FIXED_PRIO_EN to give the LSB fixed priority on
// contention (no round-robin pointer). Default build is round-robin.
//
// Ports:
//   clk, rst (async, active-high), rdy (global enable), rollback (sync flush)
//   valid/alias/result_from_alu, valid/alias/result_from_lsb : producer inputs
//   stall_to_alu, stall_to_lsb : queue full (combinational)
//   cdb_valid, cdb_alias, cdb_result, cdb_src (0=ALU, 1=LSB) : broadcast
//   overflow_err : sticky, set when a result had to be dropped
module cdb_arbiter #(
  parameter int ALIAS_WIDTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   valid_from_alu,
  input  logic [ALIAS_WIDTH-1:0] alias_from_alu,
  input  logic [DATA_WIDTH-1:0]  result_from_alu,
  input  logic                   valid_from_lsb,
  input  logic [ALIAS_WIDTH-1:0] alias_from_lsb,
  input  logic [DATA_WIDTH-1:0]  result_from_lsb,
  output logic                   stall_to_alu,
  output logic                   stall_to_lsb,
  output logic                   cdb_valid,
  output logic [ALIAS_WIDTH-1:0] cdb_alias,
  output logic [DATA_WIDTH-1:0]  cdb_result,
  output logic                   cdb_src,
  output logic                   overflow_err
);
  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int ENTRY_W = ALIAS_WIDTH + DATA_WIDTH;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(QUEUE_DEPTH);

  // Index 0 is the ALU queue, index 1 the LSB queue.
  logic [ENTRY_W-1:0] mem [2][QUEUE_DEPTH];
  logic [PTR_W-1:0]   head [2];
  logic [PTR_W-1:0]   tail [2];
  logic [PTR_W:0]     count [2];

`ifndef CDB_FIXED_PRIO_EN
  logic rr_ptr;
`endif

  logic [1:0]         in_valid;
  logic [ENTRY_W-1:0] in_entry [2];
  logic [ENTRY_W-1:0] cand_entry [2];
  logic [ENTRY_W-1:0] win_entry;
  logic [1:0]         q_empty, q_full, cand, grant, deq, enq, drop;

  assign in_valid    = {valid_from_lsb, valid_from_alu};
  assign in_entry[0] = {alias_from_alu, result_from_alu};
  assign in_entry[1] = {alias_from_lsb, result_from_lsb};

  assign stall_to_alu = (count[0] == FULL);
  assign stall_to_lsb = (count[1] == FULL);

  always_comb begin
    q_empty = '0;
    q_full  = '0;
    cand    = '0;
    grant   = '0;
    deq     = '0;
    enq     = '0;
    drop    = '0;
    for (int s = 0; s < 2; s++) begin
      q_empty[s]    = (count[s] == '0);
      q_full[s]     = (count[s] == FULL);
      // A non-empty queue always presents its head; the live input waits behind it.
      cand[s]       = !q_empty[s] || in_valid[s];
      cand_entry[s] = q_empty[s] ? in_entry[s] : mem[s][head[s]];
    end

    if (cand[0] && cand[1]) begin
`ifdef CDB_FIXED_PRIO_EN
      grant = 2'b10;
`else
      grant = rr_ptr ? 2'b10 : 2'b01;
`endif
    end else begin
      grant = cand;
    end

    for (int s = 0; s < 2; s++) begin
      deq[s]  = grant[s] && !q_empty[s];
      // An input that won directly (bypassing an empty queue) is not stored.
      enq[s]  = in_valid[s] && !(grant[s] && q_empty[s]) && (!q_full[s] || deq[s]);
      drop[s] = in_valid[s] && q_full[s] && !deq[s];
    end

    win_entry = grant[1] ? cand_entry[1] : cand_entry[0];
  end

  // Queue storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int s = 0; s < 2; s++) begin
        if (enq[s]) mem[s][tail[s]] <= in_entry[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      cdb_valid    <= 1'b0;
      cdb_alias    <= '0;
      cdb_result   <= '0;
      cdb_src      <= 1'b0;
      overflow_err <= 1'b0;
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr       <= 1'b0;
`endif
    end else if (rdy) begin
      if (rollback) begin
        for (int s = 0; s < 2; s++) begin
          head[s]  <= '0;
          tail[s]  <= '0;
          count[s] <= '0;
        end
        cdb_valid <= 1'b0;
`ifndef CDB_FIXED_PRIO_EN
        rr_ptr    <= 1'b0;
`endif
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (deq[s]) head[s] <= head[s] + PTR_W'(1);
          if (enq[s]) tail[s] <= tail[s] + PTR_W'(1);
          if (enq[s] && !deq[s])      count[s] <= count[s] + (PTR_W+1)'(1);
          else if (deq[s] && !enq[s]) count[s] <= count[s] - (PTR_W+1)'(1);
        end
        cdb_valid <= |grant;
        if (|grant) begin
          cdb_alias  <= win_entry[ENTRY_W-1:DATA_WIDTH];
          cdb_result <= win_entry[DATA_WIDTH-1:0];
          cdb_src    <= grant[1];
`ifndef CDB_FIXED_PRIO_EN
          // Point at whichever source did not just win.
          rr_ptr     <= grant[0];
`endif
        end
        if (|drop) overflow_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  logic valid_from_alu, valid_from_lsb;
  logic [AW-1:0] alias_from_alu, alias_from_lsb;
  logic [DW-1:0] result_from_alu, result_from_lsb;
  logic stall_to_alu, stall_to_lsb;
  logic cdb_valid, cdb_src, overflow_err;
  logic [AW-1:0] cdb_alias;
  logic [DW-1:0] cdb_result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.ALIAS_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .valid_from_alu(valid_from_alu), .alias_from_alu(alias_from_alu), .result_from_alu(result_from_alu),
    .valid_from_lsb(valid_from_lsb), .alias_from_lsb(alias_from_lsb), .result_from_lsb(result_from_lsb),
    .stall_to_alu(stall_to_alu), .stall_to_lsb(stall_to_lsb),
    .cdb_valid(cdb_valid), .cdb_alias(cdb_alias), .cdb_result(cdb_result), .cdb_src(cdb_src),
    .overflow_err(overflow_err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] r;
  } ent_t;

  // Reference model: pending results per source as plain queues.
  ent_t qa[$];
  ent_t ql[$];
  bit m_rr, m_valid, m_src, m_ovf;
  logic [AW-1:0] m_alias;
  logic [DW-1:0] m_result;
  logic [AW-1:0] log_a[$];
  logic [AW-1:0] log_l[$];

  function automatic void model_reset();
    qa.delete();
    ql.delete();
    m_rr = 0; m_valid = 0; m_src = 0; m_ovf = 0;
    m_alias = '0; m_result = '0;
  endfunction

  function automatic void model_step(bit va, ent_t ia, bit vl, ent_t il, bit rb, bit rd);
    bit ca, cl, wa, wl, pa, pl;
    ent_t ea, el;
    if (!rd) return;
    if (rb) begin
      qa.delete();
      ql.delete();
      m_valid = 0;
      m_rr = 0;
      return;
    end
    ca = (qa.size() != 0) || va;
    cl = (ql.size() != 0) || vl;
    ea = (qa.size() != 0) ? qa[0] : ia;
    el = (ql.size() != 0) ? ql[0] : il;
`ifdef CDB_FIXED_PRIO_EN
    wl = cl;
    wa = ca && !cl;
`else
    if (ca && cl) begin
      wa = !m_rr;
      wl = m_rr;
    end else begin
      wa = ca;
      wl = cl;
    end
`endif
    pa = wa && (qa.size() != 0);
    pl = wl && (ql.size() != 0);
    if (pa) void'(qa.pop_front());
    if (pl) void'(ql.pop_front());
    if (va && !(wa && !pa)) begin
      if (qa.size() == DEPTH) m_ovf = 1;
      else qa.push_back(ia);
    end
    if (vl && !(wl && !pl)) begin
      if (ql.size() == DEPTH) m_ovf = 1;
      else ql.push_back(il);
    end
    m_valid = wa || wl;
    if (wl) begin
      m_alias = el.a; m_result = el.r; m_src = 1;
    end else if (wa) begin
      m_alias = ea.a; m_result = ea.r; m_src = 0;
    end
    if (wa || wl) m_rr = wa;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(m_valid));
    chk({tag, ".alias"}, 64'(cdb_alias), 64'(m_alias));
    chk({tag, ".result"}, 64'(cdb_result), 64'(m_result));
    chk({tag, ".src"}, 64'(cdb_src), 64'(m_src));
    chk({tag, ".ovf"}, 64'(overflow_err), 64'(m_ovf));
  endtask

  // One clock: drive at edge+1, check stalls before the edge, outputs after it.
  task automatic cyc(input bit va, input logic [AW-1:0] aa, input logic [DW-1:0] ra,
                     input bit vl, input logic [AW-1:0] al, input logic [DW-1:0] rl,
                     input bit rb, input bit rd, input string tag);
    ent_t ia, il;
    valid_from_alu = va; alias_from_alu = aa; result_from_alu = ra;
    valid_from_lsb = vl; alias_from_lsb = al; result_from_lsb = rl;
    rollback = rb; rdy = rd;
    #1;
    chk({tag, ".stall_alu"}, 64'(stall_to_alu), 64'(qa.size() == DEPTH));
    chk({tag, ".stall_lsb"}, 64'(stall_to_lsb), 64'(ql.size() == DEPTH));
    ia.a = aa; ia.r = ra;
    il.a = al; il.r = rl;
    model_step(va, ia, vl, il, rb, rd);
    @(posedge clk);
    #1;
    check_all(tag);
    if (cdb_valid === 1'b1) begin
      if (cdb_src === 1'b1) log_l.push_back(cdb_alias);
      else log_a.push_back(cdb_alias);
    end
  endtask

  task automatic idle(input string tag);
    cyc(0, '0, '0, 0, '0, '0, 0, 1, tag);
  endtask

  task automatic do_reset();
    valid_from_alu = 0; valid_from_lsb = 0; rollback = 0; rdy = 1;
    rst = 1;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int na, nl;
    rst = 1; rdy = 1; rollback = 0;
    valid_from_alu = 0; valid_from_lsb = 0;
    alias_from_alu = '0; alias_from_lsb = '0;
    result_from_alu = '0; result_from_lsb = '0;
    model_reset();
    #12;
    chk("reset.valid", 64'(cdb_valid), 64'd0);
    chk("reset.alias", 64'(cdb_alias), 64'd0);
    chk("reset.result", 64'(cdb_result), 64'd0);
    chk("reset.src", 64'(cdb_src), 64'd0);
    chk("reset.ovf", 64'(overflow_err), 64'd0);
    chk("reset.stall_alu", 64'(stall_to_alu), 64'd0);
    chk("reset.stall_lsb", 64'(stall_to_lsb), 64'd0);
    rst = 0;

    // Uncontended ALU result: one-cycle latency, single-cycle broadcast.
    cyc(1, 4'd3, 32'h11, 0, '0, '0, 0, 1, "unc0");
    chk("unc.c1.valid", 64'(cdb_valid), 64'd1);
    chk("unc.c1.alias", 64'(cdb_alias), 64'd3);
    chk("unc.c1.result", 64'(cdb_result), 64'h11);
    chk("unc.c1.src", 64'(cdb_src), 64'd0);
    idle("unc1");
    chk("unc.c2.valid", 64'(cdb_valid), 64'd0);

    // Contention from a fresh reset.
    do_reset();
    cyc(1, 4'd1, 32'hA, 1, 4'd2, 32'hB, 0, 1, "cont0");
`ifdef CDB_FIXED_PRIO_EN
    chk("cont.c1.alias", 64'(cdb_alias), 64'd2);
    chk("cont.c1.src", 64'(cdb_src), 64'd1);
    idle("cont1");
    chk("cont.c2.alias", 64'(cdb_alias), 64'd1);
    chk("cont.c2.src", 64'(cdb_src), 64'd0);
`else
    chk("cont.c1.alias", 64'(cdb_alias), 64'd1);
    chk("cont.c1.src", 64'(cdb_src), 64'd0);
    idle("cont1");
    chk("cont.c2.alias", 64'(cdb_alias), 64'd2);
    chk("cont.c2.src", 64'(cdb_src), 64'd1);
`endif
    idle("cont2");
    cyc(1, 4'd1, 32'hA, 1, 4'd2, 32'hB, 0, 1, "cont3");
    idle("cont4");
    idle("cont5");

    // Fill and order: both producers stream, honouring stalls.
    do_reset();
    log_a.delete();
    log_l.delete();
    na = 8; nl = 1;
    for (int i = 0; i < 40; i++) begin
      bit va, vl;
      va = (na <= 13) && (qa.size() < DEPTH);
      vl = (nl <= 6) && (ql.size() < DEPTH);
      cyc(va, 4'(na), 32'(na * 16), vl, 4'(nl), 32'(nl * 256), 0, 1, "fill");
      if (va) na++;
      if (vl) nl++;
    end
    chk("fill.count_lsb", 64'(log_l.size()), 64'd6);
    chk("fill.count_alu", 64'(log_a.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_l.size(); i++) chk("fill.order_lsb", 64'(log_l[i]), 64'(i + 1));
    for (int i = 0; i < 6 && i < log_a.size(); i++) chk("fill.order_alu", 64'(log_a[i]), 64'(i + 8));
    chk("fill.ovf", 64'(overflow_err), 64'd0);

    // Overflow: LSB ignores its stall while results pile up.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      bit va;
      va = (qa.size() < DEPTH);
      cyc(va, 4'(i), 32'h2000 + 32'(i), 1, 4'(i), 32'h1000 + 32'(i), 0, 1, "ovf");
    end
    chk("ovf.set", 64'(overflow_err), 64'd1);
    for (int i = 0; i < 10; i++) idle("ovf_drain");
    chk("ovf.sticky", 64'(overflow_err), 64'd1);

    // Rollback with three results queued; overflow flag must survive.
    cyc(1, 4'd1, 32'h51, 1, 4'd2, 32'h52, 0, 1, "rb0");
    cyc(1, 4'd3, 32'h53, 1, 4'd4, 32'h54, 0, 1, "rb1");
    cyc(1, 4'd5, 32'h55, 1, 4'd6, 32'h56, 0, 1, "rb2");
    cyc(1, 4'd14, 32'hEE, 1, 4'd15, 32'hFF, 1, 1, "rb3");
    chk("rb.valid", 64'(cdb_valid), 64'd0);
    chk("rb.stall_alu", 64'(stall_to_alu), 64'd0);
    chk("rb.stall_lsb", 64'(stall_to_lsb), 64'd0);
    chk("rb.ovf_kept", 64'(overflow_err), 64'd1);
    for (int i = 0; i < 4; i++) begin
      idle("rb_after");
      chk("rb.no_stale", 64'(cdb_valid), 64'd0);
    end

    // rdy low freezes everything even with live inputs.
    do_reset();
    cyc(1, 4'd7, 32'h77, 1, 4'd9, 32'h99, 0, 1, "rdy0");
    cyc(1, 4'd1, 32'h1, 1, 4'd2, 32'h2, 0, 0, "rdy1");
    cyc(1, 4'd1, 32'h1, 1, 4'd2, 32'h2, 1, 0, "rdy2");
    idle("rdy3");
    idle("rdy4");

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) cyc(1, 4'(i), 32'(i), 1, 4'(i + 8), 32'(i + 8), 0, 1, "burst");
    rst = 1;
    #1;
    chk("async.valid", 64'(cdb_valid), 64'd0);
    chk("async.alias", 64'(cdb_alias), 64'd0);
    chk("async.result", 64'(cdb_result), 64'd0);
    chk("async.src", 64'(cdb_src), 64'd0);
    chk("async.stall_alu", 64'(stall_to_alu), 64'd0);
    chk("async.stall_lsb", 64'(stall_to_lsb), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    valid_from_alu = 0; valid_from_lsb = 0;

    // Repeated simultaneous results, then drain (priority behaviour).
    for (int i = 0; i < 10; i++) begin
      bit va, vl;
      va = (qa.size() < DEPTH);
      vl = (ql.size() < DEPTH);
      cyc(va, 4'(i), 32'h300 + 32'(i), vl, 4'(i), 32'h400 + 32'(i), 0, 1, "prio");
    end
    for (int i = 0; i < 10; i++) idle("prio_drain");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit va, vl, rb, rd;
      va = ($urandom_range(0, 2) != 0) && ((qa.size() < DEPTH) || ($urandom_range(0, 15) == 0));
      vl = ($urandom_range(0, 2) != 0) && ((ql.size() < DEPTH) || ($urandom_range(0, 15) == 0));
      rb = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 7) != 0);
      cyc(va, 4'($urandom), $urandom, vl, 4'($urandom), $urandom, rb, rd, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
